// File: rtl/wb_uart_cmd_bridge.sv
// Byte-stream command bridge: parses 'W'/'R' frames from a UART receiver, runs one
// Wishbone classic cycle per frame and streams the response bytes to a UART transmitter.
module wb_uart_cmd_bridge #(
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [7:0] ACK_BYTE       = 8'h4B,
    parameter logic [7:0] ERR_BYTE       = 8'h45
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o
);

    localparam int            TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    CMD_W    = 8'h57;
    localparam logic [7:0]    CMD_R    = 8'h52;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t        state;
    logic          we;
    logic          err;
    logic [31:0]   adr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [1:0]    byte_cnt;
    logic [TW-1:0] tmo;
    logic          rx_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          cyc;
    logic [3:0]    sel;
    logic          rx_fire;
    logic          tx_last;

    assign rx_fire = rx_valid_i && rx_ready;
    // Errors and write acks are single-byte responses; reads send four.
    assign tx_last = err || we || (byte_cnt == 2'd3);

    assign rx_ready_o = rx_ready;
    assign tx_valid_o = tx_valid;
    assign tx_data_o  = tx_data;
    assign wbm_cyc_o  = cyc;
    assign wbm_stb_o  = cyc;
    assign wbm_we_o   = we;
    assign wbm_sel_o  = sel;
    assign wbm_adr_o  = adr;
    assign wbm_dat_o  = wdata;
    assign busy_o     = (state != IDLE);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            we       <= 1'b0;
            err      <= 1'b0;
            adr      <= '0;
            wdata    <= '0;
            rdata    <= '0;
            byte_cnt <= '0;
            tmo      <= '0;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            cyc      <= 1'b0;
            sel      <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire && (rx_data_i == CMD_W || rx_data_i == CMD_R)) begin
                        we       <= (rx_data_i == CMD_W);
                        byte_cnt <= '0;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        adr      <= {adr[23:0], rx_data_i};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (we) begin
                                state <= DATA;
                            end else begin
                                state    <= BUS;
                                cyc      <= 1'b1;
                                sel      <= 4'hF;
                                rx_ready <= 1'b0;
                                tmo      <= '0;
                            end
                        end
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        wdata    <= {wdata[23:0], rx_data_i};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= BUS;
                            cyc      <= 1'b1;
                            sel      <= 4'hF;
                            rx_ready <= 1'b0;
                            tmo      <= '0;
                        end
                    end
                end
                BUS: begin
                    // An ack arriving on the terminal count still completes the access.
                    if (wbm_ack_i) begin
                        cyc      <= 1'b0;
                        sel      <= 4'h0;
                        err      <= 1'b0;
                        byte_cnt <= '0;
                        state    <= RESP;
                        if (!we) begin
                            rdata <= wbm_dat_i;
                        end
                    end else if (tmo == TMO_LAST) begin
                        cyc      <= 1'b0;
                        sel      <= 4'h0;
                        err      <= 1'b1;
                        byte_cnt <= '0;
                        state    <= RESP;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                RESP: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= err ? ERR_BYTE : (we ? ACK_BYTE : rdata[31:24]);
                    end else if (tx_ready_i) begin
                        if (tx_last) begin
                            tx_valid <= 1'b0;
                            err      <= 1'b0;
                            rx_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // Next read byte goes out straight away so transfers can run back to back.
                            byte_cnt <= byte_cnt + 2'd1;
                            tx_data  <= rdata[23:16];
                            rdata    <= {rdata[23:0], 8'h00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_cmd_bridge.sv
// Self-checking bench for wb_uart_cmd_bridge: scripted and randomized command frames
// against a frame-level model of responses, bus cycles and a backing register memory.
module tb_wb_uart_cmd_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = 32'h0;
    logic        ack = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    wb_uart_cmd_bridge #(
        .TIMEOUT_CYCLES(TO),
        .ACK_BYTE(8'h4B),
        .ERR_BYTE(8'h45)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .rx_data_i(rx_data),
        .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready),
        .tx_data_o(tx_data),
        .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_we_o(we),
        .wbm_sel_o(sel),
        .wbm_adr_o(adr),
        .wbm_dat_o(dat_o),
        .wbm_dat_i(dat_i),
        .wbm_ack_i(ack),
        .busy_o(busy)
    );

    int checks = 0;
    int failures = 0;

    int ack_delay = 1;      // slave acks after seeing stb on this many edges; -1 = never
    int tx_mode = 0;        // 0: always ready, 1: ready 1-of-3 cycles, 2: random
    int tx_phase = 0;
    int slv_cnt = 0;
    int cyc_total = 0;
    int sel_bad = 0;
    int stab_bad = 0;
    int cyc_start = 0;
    int cyc_len = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  junk_q[$];
    logic [31:0] txn_adr[$];
    logic [31:0] txn_dat[$];
    logic        txn_we[$];

    int          exp_cyc;
    bit          exp_ok;
    logic [31:0] exp_word;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Wishbone slave backed by its own memory; writes commit only on a completed handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack     <= 1'b0;
            slv_cnt <= 0;
        end else begin
            ack <= 1'b0;
            if (cyc && stb && ack) begin
                slv_cnt <= 0;
                txn_adr.push_back(adr);
                txn_we.push_back(we);
                txn_dat.push_back(we ? dat_o : dat_i);
                if (we) slv_mem[adr] = dat_o;
            end else if (cyc && stb) begin
                slv_cnt <= slv_cnt + 1;
                if (ack_delay >= 1 && slv_cnt + 1 == ack_delay) begin
                    ack   <= 1'b1;
                    dat_i <= slv_mem.exists(adr) ? slv_mem[adr] : init_word(adr);
                end
            end else begin
                slv_cnt <= 0;
            end
        end
    end

    always @(negedge clk) begin
        tx_phase = (tx_phase + 1) % 3;
        case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (tx_phase == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor samples one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (cyc) cyc_total++;
            if ((cyc && sel !== 4'hF) || (!cyc && sel !== 4'h0) || (stb !== cyc)) sel_bad++;
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            if (hold_v && tx_valid && tx_data !== hold_d) stab_bad++;
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
        end
    end

    // Frame-level reference: an ack in BUS cycle delay+1 wins if it comes within TO cycles.
    task automatic model_frame(input bit is_w, input logic [31:0] a, input logic [31:0] d, input int dl);
        logic [31:0] w;
        exp_q.delete();
        exp_ok  = (dl >= 1) && (dl + 1 <= TO);
        exp_cyc = exp_ok ? dl + 1 : TO;
        if (!exp_ok) begin
            exp_q.push_back(8'h45);
        end else if (is_w) begin
            exp_q.push_back(8'h4B);
            ref_mem[a] = d;
            exp_word = d;
        end else begin
            w = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
            exp_word = w;
            for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL rx_accept byte=%h not accepted within 200 cycles", b);
        end
        @(posedge clk);
    endtask

    task automatic issue(input bit is_w, input logic [31:0] a, input logic [31:0] d,
                         input int dl, input bit gaps);
        int n;
        ack_delay = dl;
        tx_q.delete();
        txn_adr.delete();
        txn_we.delete();
        txn_dat.delete();
        cyc_start = cyc_total;
        model_frame(is_w, a, d, dl);
        while (junk_q.size() > 0) send_byte(junk_q.pop_front(), 1'b0);
        send_byte(is_w ? 8'h57 : 8'h52, 1'b0);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], gaps && ($urandom_range(0, 3) == 0));
        if (is_w)
            for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], gaps && ($urandom_range(0, 3) == 0));
        @(negedge clk);
        rx_valid = 1'b0;
        n = 0;
        while ((tx_q.size() < exp_q.size() || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL resp_wait got_bytes=%0d exp_bytes=%0d busy=%b", tx_q.size(), exp_q.size(), busy);
        end
        repeat (3) @(negedge clk);
        cyc_len = cyc_total - cyc_start;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cyc, stb, we, sel} !== 7'h0) begin
            failures++;
            $display("FAIL reset_bus_ctrl got=%h exp=0", {cyc, stb, we, sel});
        end
        checks++;
        if ({adr, dat_o} !== 64'h0) begin
            failures++;
            $display("FAIL reset_bus_data got=%h exp=0", {adr, dat_o});
        end
        checks++;
        if ({tx_valid, tx_data, rx_ready, busy} !== 11'h0) begin
            failures++;
            $display("FAIL reset_stream got=%h exp=0", {tx_valid, tx_data, rx_ready, busy});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle rx_ready=%b busy=%b exp rx_ready=1 busy=0", rx_ready, busy);
        end
    endtask

    task automatic test_write();
        tx_mode = 0;
        issue(1'b1, 32'h3000_0008, 32'hDEAD_BEEF, 1, 1'b0);
        checks++;
        if (txn_adr.size() !== 1) begin
            failures++;
            $display("FAIL write_txn_count got=%0d exp=1", txn_adr.size());
        end else begin
            checks++;
            if ({txn_we[0], txn_adr[0], txn_dat[0]} !== {1'b1, 32'h3000_0008, 32'hDEAD_BEEF}) begin
                failures++;
                $display("FAIL write_txn got we=%b adr=%h dat=%h exp we=1 adr=30000008 dat=deadbeef",
                         txn_we[0], txn_adr[0], txn_dat[0]);
            end
        end
        checks++;
        if (cyc_len !== 2) begin
            failures++;
            $display("FAIL write_cyc_len got=%0d exp=2", cyc_len);
        end
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
            failures++;
            $display("FAIL write_resp got_n=%0d first=%h exp 1 byte 4b", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00);
        end
        checks++;
        if (sel_bad !== 0) begin
            failures++;
            $display("FAIL write_sel_stb got=%0d bad samples exp=0", sel_bad);
        end
    endtask

    task automatic test_readback();
        logic [31:0] got;
        tx_mode = 0;
        issue(1'b0, 32'h3000_0008, 32'h0, 1, 1'b0);
        got = 32'h0;
        foreach (tx_q[i]) if (i < 4) got[8*(3-i) +: 8] = tx_q[i];
        checks++;
        if (tx_q.size() !== 4 || got !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL readback_resp got_n=%0d got=%h exp_n=4 exp=deadbeef", tx_q.size(), got);
        end
        checks++;
        if (txn_adr.size() !== 1 || txn_we[0] !== 1'b0 || txn_adr[0] !== 32'h3000_0008) begin
            failures++;
            $display("FAIL readback_txn got_n=%0d exp one read at 30000008", txn_adr.size());
        end
    endtask

    task automatic test_timeout();
        tx_mode = 0;
        issue(1'b0, 32'h3000_0010, 32'h0, -1, 1'b0);
        checks++;
        if (cyc_len !== TO) begin
            failures++;
            $display("FAIL timeout_cyc_len got=%0d exp=%0d", cyc_len, TO);
        end
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h45) begin
            failures++;
            $display("FAIL timeout_resp got_n=%0d first=%h exp 1 byte 45", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00);
        end
        checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b1 || txn_adr.size() !== 0) begin
            failures++;
            $display("FAIL timeout_idle busy=%b rx_ready=%b txns=%0d exp 0 1 0", busy, rx_ready, txn_adr.size());
        end
    endtask

    task automatic test_garbage_backpressure();
        tx_mode = 1;
        stab_bad = 0;
        junk_q.push_back(8'h00);
        junk_q.push_back(8'hFF);
        issue(1'b0, 32'h3000_0008, 32'h0, 1, 1'b0);
        checks++;
        if (tx_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL garbage_resp_len got=%0d exp=%0d", tx_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (tx_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL garbage_resp_byte%0d got=%h exp=%h", i, tx_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (txn_adr.size() !== 1) begin
            failures++;
            $display("FAIL garbage_txn_count got=%0d exp=1", txn_adr.size());
        end
        checks++;
        if (stab_bad !== 0) begin
            failures++;
            $display("FAIL tx_hold_stable got=%0d changes exp=0", stab_bad);
        end
        tx_mode = 0;
    endtask

    task automatic test_reset_mid_cycle();
        tx_mode = 0;
        ack_delay = -1;
        send_byte(8'h52, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (cyc !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_precond cyc=%b busy=%b exp 1 1", cyc, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cyc, stb, tx_valid, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_async got cyc,stb,tx_valid,busy=%b exp=0000", {cyc, stb, tx_valid, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        tx_q.delete();
        issue(1'b1, 32'h3000_0004, 32'h1234_5678, 2, 1'b0);
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
            failures++;
            $display("FAIL midrst_write_resp got_n=%0d first=%h exp 1 byte 4b", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00);
        end
        checks++;
        if (txn_adr.size() !== 1 || txn_adr[0] !== 32'h3000_0004 || txn_dat[0] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL midrst_write_txn got_n=%0d exp one write 30000004=12345678", txn_adr.size());
        end
        checks++;
        if (cyc_len !== 3) begin
            failures++;
            $display("FAIL midrst_cyc_len got=%0d exp=3", cyc_len);
        end
    endtask

    task automatic test_ack_terminal();
        logic [31:0] got;
        tx_mode = 0;
        issue(1'b1, 32'h3000_000C, 32'hCAFE_F00D, TO - 1, 1'b0);
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B || cyc_len !== TO) begin
            failures++;
            $display("FAIL term_write got_n=%0d first=%h cyc=%0d exp 1 byte 4b cyc=%0d",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00, cyc_len, TO);
        end
        issue(1'b0, 32'h3000_000C, 32'h0, TO - 1, 1'b0);
        got = 32'h0;
        foreach (tx_q[i]) if (i < 4) got[8*(3-i) +: 8] = tx_q[i];
        checks++;
        if (tx_q.size() !== 4 || got !== exp_word) begin
            failures++;
            $display("FAIL term_read got_n=%0d got=%h exp_n=4 exp=%h", tx_q.size(), got, exp_word);
        end
        issue(1'b1, 32'h3000_000C, 32'h0BAD_0BAD, TO, 1'b0);
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h45 || txn_adr.size() !== 0) begin
            failures++;
            $display("FAIL late_ack_err got_n=%0d first=%h txns=%0d exp 1 byte 45 and 0 txns",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00, txn_adr.size());
        end
    endtask

    task automatic test_random();
        bit          is_w;
        logic [31:0] a, d;
        int          dl, r;
        for (int k = 0; k < 25; k++) begin
            is_w = 1'($urandom_range(0, 1));
            a    = 32'h3000_0000 + 32'(4 * $urandom_range(0, 3));
            d    = $urandom;
            r    = $urandom_range(0, 9);
            dl   = (r < 5) ? $urandom_range(1, 4) : (r == 5) ? TO - 1 : (r == 6) ? TO :
                   (r == 7) ? -1 : $urandom_range(5, 14);
            tx_mode = $urandom_range(0, 2);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                r = $urandom_range(0, 255);
                junk_q.push_back((r == 8'h57 || r == 8'h52) ? 8'h00 : 8'(r));
            end
            issue(is_w, a, d, dl, 1'b1);
            checks++;
            if (tx_q.size() !== exp_q.size()) begin
                failures++;
                $display("FAIL rand%0d_resp_len got=%0d exp=%0d", k, tx_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (tx_q[i] !== exp_q[i]) begin
                        failures++;
                        $display("FAIL rand%0d_byte%0d got=%h exp=%h", k, i, tx_q[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (cyc_len !== exp_cyc) begin
                failures++;
                $display("FAIL rand%0d_cyc_len got=%0d exp=%0d", k, cyc_len, exp_cyc);
            end
            checks++;
            if (txn_adr.size() !== (exp_ok ? 1 : 0)) begin
                failures++;
                $display("FAIL rand%0d_txn_count got=%0d exp=%0d", k, txn_adr.size(), exp_ok ? 1 : 0);
            end else if (exp_ok) begin
                checks++;
                if (txn_adr[0] !== a || txn_we[0] !== is_w || txn_dat[0] !== exp_word) begin
                    failures++;
                    $display("FAIL rand%0d_txn got adr=%h we=%b dat=%h exp adr=%h we=%b dat=%h",
                             k, txn_adr[0], txn_we[0], txn_dat[0], a, is_w, exp_word);
                end
            end
        end
        checks++;
        if (sel_bad !== 0 || stab_bad !== 0) begin
            failures++;
            $display("FAIL rand_protocol sel_bad=%0d stab_bad=%0d exp 0 0", sel_bad, stab_bad);
        end
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_readback();
        test_timeout();
        test_garbage_backpressure();
        test_reset_mid_cycle();
        test_ack_terminal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_uart_cmd_bridge.md
Name: wb_uart_cmd_bridge

Overview:
- Byte-stream-to-Wishbone command bridge. Sits directly upstream of the debug register slave and other Wishbone slaves.
- Consumes command bytes from a UART receiver over a valid/ready byte interface and issues single Wishbone classic read/write cycles.
- Returns response bytes to a UART transmitter.
- Gives external debug access to the debug registers without the CPU.

Parameters:
- TIMEOUT_CYCLES, 16, Wishbone cycles to wait for wbm_ack_i before aborting (must be >= 2).
- ACK_BYTE, 8'h4B, response byte for a completed write.
- ERR_BYTE, 8'h45, response byte for a timed-out access.

Ports:
- wb_clk_i  input  1  Wishbone clock; all logic rises on posedge.
- wb_rst_i  input  1  Reset, asynchronous, active-high.
- rx_data_i  input  8  Command byte from UART RX.
- rx_valid_i  input  1  rx_data_i valid.
- rx_ready_o  output  1  Bridge accepts byte this cycle.
- tx_data_o  output  8  Response byte to UART TX.
- tx_valid_o  output  1  tx_data_o valid.
- tx_ready_i  input  1  TX accepts byte this cycle.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  1 = write.
- wbm_sel_o  output  4  Byte selects; always 4'hF during a cycle, 0 otherwise.
- wbm_adr_o  output  32  Address.
- wbm_dat_o  output  32  Write data.
- wbm_dat_i  input  32  Read data.
- wbm_ack_i  input  1  Slave acknowledge.
- busy_o  output  1  High in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; address, data, byte and timeout counters 0. Reset is honoured mid-frame, mid-bus-cycle and mid-response: cyc/stb drop immediately and the partial frame is discarded.
- A byte transfers when rx_valid_i && rx_ready_o. A response byte transfers when tx_valid_o && tx_ready_i.
- rx_ready_o = 1 only in IDLE, ADDR and DATA. It is a registered state decode.
- Frame format (all multi-byte fields MSB first):
  - Write: 'W' (8'h57), 4 address bytes, 4 data bytes.
  - Read: 'R' (8'h52), 4 address bytes.
- IDLE:
  - 'W' or 'R' accepted: latch we, clear byte count, go to ADDR.
  - Any other byte: accepted and dropped; stay IDLE.
- ADDR:
  - Each accepted byte shifts into the address register (adr <= {adr[23:0], byte}).
  - After the 4th byte: go to DATA if write, else go to BUS.
- DATA: the 4 accepted bytes shift into the write data register; after the 4th byte go to BUS.
- BUS entry: cyc, stb and sel=F are asserted on the clock edge that enters BUS. adr, dat_o and we are stable for the whole cycle.
- BUS exit on ack: on the first edge where wbm_ack_i=1, cyc/stb/sel are deasserted on that same edge. A read latches wbm_dat_i on that edge. Go to RESP.
- BUS exit on timeout: the timeout counter increments each BUS cycle without ack. When it reaches TIMEOUT_CYCLES-1 and no ack is present, deassert cyc/stb and go to RESP with the error flag set. If ack and terminal count coincide, ack wins (not an error).
- wbm_ack_i outside BUS is ignored.
- RESP byte sequence:
  - Error: 1 byte, ERR_BYTE.
  - Write success: 1 byte, ACK_BYTE.
  - Read success: 4 bytes, rdata[31:24], [23:16], [15:8], [7:0].
- RESP handshake:
  - tx_valid_o rises the cycle after RESP entry.
  - tx_data_o is held stable until accepted.
  - The next byte is presented on the cycle after acceptance; back-to-back acceptance is allowed.
  - After the last byte is accepted, tx_valid_o drops and the state returns to IDLE.
- Bytes arriving on rx_* during BUS/RESP are not accepted (rx_ready_o=0); the upstream holds them.
- No inter-byte timeout; a partial frame waits indefinitely.
- Best-case latency: read with a one-cycle-ack slave gives the first tx_valid_o 3 cycles after the last address byte is accepted.

Test Plan:
- Write reg: send 57 30 00 00 08 DE AD BE EF with a slave acking the cycle after stb. Required: one Wishbone write, adr=3000_0008, dat=DEADBEEF, sel=F, cyc high exactly 2 cycles; tx byte 4B.
- Readback: send 52 30 00 00 08 after the write above. Required: read cycle at 3000_0008; tx bytes DE AD BE EF in order.
- Timeout: read 3000_0010 with no ack, TIMEOUT_CYCLES=16. Required: cyc high exactly 16 cycles; tx byte 45; bridge returns to IDLE.
- Garbage and backpressure: send 00 FF then a valid read, with tx_ready_i toggling 1-of-3 cycles. Required: garbage dropped; 4 correct bytes; tx_data_o stable while tx_valid_o && !tx_ready_i.
- Reset mid-cycle: assert wb_rst_i while cyc=1. Required: cyc/stb/tx_valid_o/busy_o go 0 asynchronously; a following full write frame completes normally.
- Ack at terminal count: slave acks in the 16th BUS cycle. Required: response is 4B (write) or data bytes (read), not 45.
